// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI/DVI video timing generator.
// - Default 640x480@60 raster timing constants.
// - Test-pattern selector enum.
// - Colour-bar RGB table (24-bit {R,G,B}) and a lookup helper.
package hdmi_pkg;

  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_WHITE = 2'd2,
    PAT_BLACK = 2'd3
  } pattern_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Bar colour by bar index, left (0) to right (7).
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_video_timing_gen_if.sv
// Video link bundle between the timing generator and its consumer.
// - pix_ce, pattern_sel : controls into the generator
// - hsync, vsync, vde, ctrl_blue, red, green, blue, frame_start : registered
//   outputs feeding the TMDS encoders
// master = the generator, slave = the consumer/controller.
interface hdmi_video_timing_gen_if;
  logic       pix_ce;
  logic [1:0] pattern_sel;
  logic       hsync;
  logic       vsync;
  logic       vde;
  logic [1:0] ctrl_blue;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       frame_start;

  modport master (
    input  pix_ce, pattern_sel,
    output hsync, vsync, vde, ctrl_blue, red, green, blue, frame_start
  );

  modport slave (
    output pix_ce, pattern_sel,
    input  hsync, vsync, vde, ctrl_blue, red, green, blue, frame_start
  );
endinterface

// File: rtl/hdmi_pattern_gen.sv
// Combinational test-pattern source: (h, v, pat) -> 24-bit {R,G,B}.
// - h    : 10-bit pixel column
// - v_lo : low 8 bits of the line number (only the gradient uses v)
// - pat  : selected pattern
// - rgb  : pixel colour; caller gates it with the active-area flag
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE
) (
  input  logic [9:0]  h,
  input  logic [7:0]  v_lo,
  input  pattern_e    pat,
  output logic [23:0] rgb
);

  localparam logic [9:0] BAR_W    = 10'(H_ACTIVE / 8);
  // Pixels at or beyond 8 whole bars are the division remainder: black.
  localparam logic [9:0] BARS_END = 10'((H_ACTIVE / 8) * 8);

  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'(h / BAR_W);
    rgb     = 24'h000000;
    case (pat)
      PAT_BARS:  rgb = (h < BARS_END) ? bar_color(bar_idx) : BAR_BLACK;
      PAT_GRAD:  rgb = {h[7:0], v_lo, h[7:0] ^ v_lo};
      PAT_WHITE: rgb = 24'hFFFFFF;
      default:   rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// Raster timing and test-pattern generator for one DVI/HDMI link.
// - clk, rst : single clock, synchronous active-high reset
// - vid      : master side of the video bundle (pix_ce/pattern_sel in;
//              hsync, vsync, vde, ctrl_blue, red/green/blue, frame_start out)
// Every output comes straight from a register loaded on pix_ce cycles, one
// pix_ce cycle after the counter state it describes.
module hdmi_video_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE  = C_H_ACTIVE,
  parameter int H_FP      = C_H_FP,
  parameter int H_SYNC    = C_H_SYNC,
  parameter int H_BP      = C_H_BP,
  parameter int V_ACTIVE  = C_V_ACTIVE,
  parameter int V_FP      = C_V_FP,
  parameter int V_SYNC    = C_V_SYNC,
  parameter int V_BP      = C_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  hdmi_video_timing_gen_if.master vid
);

  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_reg, h_cnt_next;
  logic [9:0]  v_cnt_reg, v_cnt_next;
  pattern_e    pat_q_reg, pat_eff;
  logic        hsync_reg, vsync_reg, vde_reg, frame_start_reg;
  logic [23:0] rgb_reg;
  logic [23:0] rgb_w;
  logic        active, hs_on, vs_on, frame_origin;

  always_comb begin
    h_cnt_next   = (h_cnt_reg == H_LAST) ? 10'd0 : h_cnt_reg + 10'd1;
    v_cnt_next   = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
    end
    active       = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    hs_on        = (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
    vs_on        = (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
    frame_origin = (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
    // The pattern is latched at the frame origin, and the origin pixel itself
    // already uses the newly selected pattern so a frame is never mixed.
    pat_eff      = frame_origin ? pattern_e'(vid.pattern_sel) : pat_q_reg;
  end

  hdmi_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .h    (h_cnt_reg),
    .v_lo (v_cnt_reg[7:0]),
    .pat  (pat_eff),
    .rgb  (rgb_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg       <= 10'd0;
      v_cnt_reg       <= 10'd0;
      pat_q_reg       <= PAT_BARS;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      vde_reg         <= 1'b0;
      rgb_reg         <= 24'h000000;
      frame_start_reg <= 1'b0;
    end else if (vid.pix_ce) begin
      h_cnt_reg       <= h_cnt_next;
      v_cnt_reg       <= v_cnt_next;
      pat_q_reg       <= pat_eff;
      hsync_reg       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
      vsync_reg       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
      vde_reg         <= active;
      rgb_reg         <= active ? rgb_w : 24'h000000;
      frame_start_reg <= frame_origin;
    end else begin
      // Keeps frame_start a single clock wide when pix_ce is sparse.
      frame_start_reg <= 1'b0;
    end
  end

  assign vid.hsync       = hsync_reg;
  assign vid.vsync       = vsync_reg;
  assign vid.vde         = vde_reg;
  assign vid.ctrl_blue   = {vsync_reg, hsync_reg};
  assign vid.red         = rgb_reg[23:16];
  assign vid.green       = rgb_reg[15:8];
  assign vid.blue        = rgb_reg[7:0];
  assign vid.frame_start = frame_start_reg;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Bench for hdmi_video_timing_gen: full 800-pixel lines, shortened frame
// (12 lines) so several whole frames fit in a short run. The reference model
// walks a linear pixel index through the frame and derives every output from it.
module tb_hdmi_video_timing_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hdmi_video_timing_gen_if vif ();

  hdmi_video_timing_gen #(
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vif)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int          pos   = 0;
  logic [1:0]  pat_m = 2'd0;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_vde = 1'b0, e_fs = 1'b0;
  logic [23:0] e_rgb = 24'h0;
  int          ox = 0, oy = 0;
  logic [1:0]  opat = 2'd0;
  bit          ovalid = 1'b0;

  // statistics window
  int   idx, vde_cnt, hs_low_line0, vs_low_cnt, fs_cnt, non_white;
  int   first_vde_rise, second_vde_rise, first_hs_fall, first_vs_fall;
  logic p_vde, p_hs, p_vs;

  function automatic logic [23:0] bar_ref(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] ref_rgb(input int x, input int y, input logic [1:0] p);
    int r, g;
    if (!(x < HA && y < VA)) return 24'h0;
    r = x % 256;
    g = y % 256;
    case (p)
      2'd0: return ((x / (HA / 8)) >= 8) ? 24'h0 : bar_ref(x / (HA / 8));
      2'd1: return {r[7:0], g[7:0], r[7:0] ^ g[7:0]};
      2'd2: return 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    idx = 0; vde_cnt = 0; hs_low_line0 = 0; vs_low_cnt = 0; fs_cnt = 0; non_white = 0;
    first_vde_rise = -1; second_vde_rise = -1; first_hs_fall = -1; first_vs_fall = -1;
    p_vde = vif.vde; p_hs = vif.hsync; p_vs = vif.vsync;
  endtask

  task automatic step(input bit ce, input bit r, input logic [1:0] sel);
    int x, y;
    logic [29:0] obs, exp;
    vif.pix_ce      = ce;
    vif.pattern_sel = sel;
    rst             = r;
    if (r) begin
      pos = 0; pat_m = 2'd0;
      e_hs = 1'b1; e_vs = 1'b1; e_vde = 1'b0; e_rgb = 24'h0; e_fs = 1'b0;
      ovalid = 1'b0;
    end else if (ce) begin
      x = pos % HT;
      y = pos / HT;
      if (pos == 0) pat_m = sel;
      e_vde  = (x < HA) && (y < VA);
      e_hs   = !((x >= HA + HF) && (x < HA + HF + HS));
      e_vs   = !((y >= VA + VF) && (y < VA + VF + VS));
      e_rgb  = ref_rgb(x, y, pat_m);
      e_fs   = (pos == 0);
      ox = x; oy = y; opat = pat_m; ovalid = 1'b1;
      pos = (pos + 1) % FRAME;
    end else begin
      e_fs   = 1'b0;
      ovalid = 1'b0;
    end
    @(posedge clk);
    #1;
    obs = {vif.hsync, vif.vsync, vif.vde, vif.ctrl_blue, vif.red, vif.green, vif.blue,
           vif.frame_start};
    exp = {e_hs, e_vs, e_vde, e_vs, e_hs, e_rgb, e_fs};
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL pixel x=%0d y=%0d ce=%0b rst=%0b observed=%h expected=%h",
             ox, oy, ce, r, obs, exp);
    end
    // spot values stated as literals
    if (ovalid && opat == 2'd0 && oy == 1) begin
      if (ox == 0)   check("bars_x0",   {vif.red, vif.green, vif.blue}, 24'hFFFFFF);
      if (ox == 80)  check("bars_x80",  {vif.red, vif.green, vif.blue}, 24'hFFFF00);
      if (ox == 639) check("bars_x639", {vif.red, vif.green, vif.blue}, 24'h000000);
    end
    if (ovalid && opat == 2'd1 && oy == 3 && ox == 300)
      check("grad_300_3", {vif.red, vif.green, vif.blue}, 24'h2C032F);
    // window statistics over enabled cycles
    if (vif.frame_start) fs_cnt++;
    if (ce && !r) begin
      if (vif.vde) vde_cnt++;
      if (vif.vde && !p_vde) begin
        if (first_vde_rise < 0) first_vde_rise = idx;
        else if (second_vde_rise < 0) second_vde_rise = idx;
      end
      if (!vif.hsync && idx < HT) hs_low_line0++;
      if (!vif.hsync && p_hs && first_hs_fall < 0) first_hs_fall = idx;
      if (!vif.vsync) vs_low_cnt++;
      if (!vif.vsync && p_vs && first_vs_fall < 0) first_vs_fall = idx;
      if (vif.vde && {vif.red, vif.green, vif.blue} != 24'hFFFFFF) non_white++;
      p_vde = vif.vde; p_hs = vif.hsync; p_vs = vif.vsync;
      idx++;
    end
  endtask

  initial begin
    logic [1:0] s;
    vif.pix_ce      = 1'b1;
    vif.pattern_sel = 2'd0;

    // reset held 3 cycles with pix_ce=1
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'd0);
      check("rst_vde", vif.vde, 1'b0);
      check("rst_hsync", vif.hsync, 1'b1);
      check("rst_vsync", vif.vsync, 1'b1);
      check("rst_rgb", {vif.red, vif.green, vif.blue}, 24'h0);
    end

    // frame 1: bars, pattern_sel switched to white at line 3 mid-frame
    clear_stats();
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0, (i >= 3 * HT) ? 2'd2 : 2'd0);
      if (i == 0) check("first_fs", vif.frame_start, 1'b1);
    end
    check("f1_vde_count", vde_cnt, VA * HA);
    check("f1_vde_rise0", first_vde_rise, 0);
    check("f1_hs_low", hs_low_line0, HS);
    check("f1_hs_fall_ofs", first_hs_fall - first_vde_rise, HA + HF);
    check("f1_line_period", second_vde_rise - first_vde_rise, HT);
    check("f1_vs_low", vs_low_cnt, VS * HT);
    check("f1_vs_fall", first_vs_fall, (VA + VF) * HT);
    check("f1_fs_count", fs_cnt, 1);

    // frame 2: white latched at origin, random sel afterwards must not matter
    clear_stats();
    for (int i = 0; i < FRAME; i++) begin
      s = (i == 0) ? 2'd2 : 2'($urandom_range(3));
      step(1'b1, 1'b0, s);
    end
    check("f2_non_white", non_white, 0);
    check("f2_vde_count", vde_cnt, VA * HA);
    check("f2_fs_count", fs_cnt, 1);

    // frame 3: gradient
    clear_stats();
    for (int i = 0; i < FRAME; i++) begin
      s = (i == 0) ? 2'd1 : 2'($urandom_range(3));
      step(1'b1, 1'b0, s);
    end
    check("f3_vde_count", vde_cnt, VA * HA);

    // frame 4: pix_ce alternating 1/0, random pattern
    clear_stats();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step((i % 2) == 0, 1'b0, 2'($urandom_range(3)));
    end
    check("f4_fs_count", fs_cnt, 1);
    check("f4_vde_count", vde_cnt, VA * HA);
    check("f4_hs_fall_ofs", first_hs_fall - first_vde_rise, HA + HF);
    check("f4_vs_low", vs_low_cnt, VS * HT);

    // random pix_ce mid-frame, then a reset pulse
    for (int i = 0; i < 4 * HT + 123; i++) begin
      step(1'($urandom_range(1)), 1'b0, 2'($urandom_range(3)));
    end
    step(1'b1, 1'b1, 2'($urandom_range(3)));
    clear_stats();
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0, 2'($urandom_range(3)));
      if (i == 0) check("post_rst_fs", vif.frame_start, 1'b1);
    end
    check("post_rst_vde_count", vde_cnt, VA * HA);
    check("post_rst_fs_count", fs_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
